// File: rtl/adc_serial_capture.sv
// -----------------------------------------------------------------------------
// adc_serial_capture
//
// Runs one 3-wire serial ADC read (cs_n / sclk / sdo) per frame strobe and
// hands the parallel result to downstream logic with a one-cycle valid pulse.
//
// Everything runs in the 150 MHz domain. The 470 kHz frame strobe and the
// 5 MHz bit clock come from a divider in the same domain. They are treated as
// data levels and edge-detected against a one-cycle delayed copy. They never
// clock any flop.
//
// Ports
//   clk150M_in    system clock, 150 MHz
//   rst_n         asynchronous active-low reset
//   enable        1 = accept frame triggers (gates frame start only)
//   clk470k_in    frame strobe level; a rising edge requests a frame
//   clk5M_in      bit clock level; adc_sclk is this level delayed by 1 cycle
//   adc_sdo       serial data from the ADC, sampled on each bit clock rise
//   adc_cs_n      ADC chip select, active low, registered
//   adc_sclk      ADC serial clock, registered
//   sample_data   last captured sample, MSB first on the wire
//   sample_valid  one-cycle pulse in the cycle sample_data updates
//   overrun       one-cycle pulse when a frame strobe arrives while busy
// -----------------------------------------------------------------------------
module adc_serial_capture #(
   parameter int DATA_BITS = 10
) (
   input  logic                 clk150M_in,
   input  logic                 rst_n,
   input  logic                 enable,
   input  logic                 clk470k_in,
   input  logic                 clk5M_in,
   input  logic                 adc_sdo,
   output logic                 adc_cs_n,
   output logic                 adc_sclk,
   output logic [DATA_BITS-1:0] sample_data,
   output logic                 sample_valid,
   output logic                 overrun
);

   // bit_cnt must be able to hold DATA_BITS itself, the value it reaches
   // on the final rise before DONE clears it.
   localparam int               CNT_W    = $clog2(DATA_BITS + 1);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_BITS - 1);

   typedef enum logic [2:0] {
      IDLE,
      ARM,
      SHIFT,
      TAIL,
      DONE
   } state_t;

   state_t               state;
   logic                 clk470k_q;
   logic                 clk5M_q;
   logic [DATA_BITS-1:0] shreg;
   logic [DATA_BITS-1:0] shreg_nxt;
   logic [CNT_W-1:0]     bit_cnt;
   logic                 trig;
   logic                 rise;

   // ---------------------------------------------------------------------------
   // Input edge detection
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk150M_in or negedge rst_n) begin
      if (!rst_n) begin
         clk470k_q <= 1'b0;
         clk5M_q   <= 1'b0;
      end else begin
         clk470k_q <= clk470k_in;
         clk5M_q   <= clk5M_in;
      end
   end

   assign trig = clk470k_in & ~clk470k_q;
   assign rise = clk5M_in & ~clk5M_q;

   // A one-bit capture has nothing to shift along; the new bit simply
   // replaces the register.
   generate
      if (DATA_BITS == 1) begin : g_shift_one
         assign shreg_nxt = adc_sdo;
      end else begin : g_shift_many
         assign shreg_nxt = {shreg[DATA_BITS-2:0], adc_sdo};
      end
   endgenerate

   // ---------------------------------------------------------------------------
   // Frame sequencer
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk150M_in or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         adc_cs_n     <= 1'b1;
         adc_sclk     <= 1'b0;
         shreg        <= '0;
         bit_cnt      <= '0;
         sample_data  <= '0;
         sample_valid <= 1'b0;
         overrun      <= 1'b0;
      end else begin
         sample_valid <= 1'b0;
         // A strobe outside IDLE is dropped; the running frame carries on.
         // This includes the DONE cycle, since state has not yet returned.
         overrun      <= trig & (state != IDLE);

         case (state)
            IDLE: begin
               adc_cs_n <= 1'b1;
               adc_sclk <= 1'b0;
               if (trig && enable) begin
                  adc_cs_n <= 1'b0;
                  state    <= ARM;
               end
            end

            // Hold sclk low until the bit clock is low, so the first sclk
            // high phase is a full one and starts at least one cycle after
            // cs_n has fallen.
            ARM: begin
               adc_cs_n <= 1'b0;
               adc_sclk <= 1'b0;
               if (!clk5M_in) begin
                  state <= SHIFT;
               end
            end

            // sclk is registered from the bit clock level, so it goes high
            // on the same edge that samples sdo.
            SHIFT: begin
               adc_sclk <= clk5M_in;
               if (rise) begin
                  shreg   <= shreg_nxt;
                  bit_cnt <= bit_cnt + CNT_W'(1);
                  if (bit_cnt == LAST_BIT) begin
                     state <= TAIL;
                  end
               end
            end

            // Let the last sclk high phase run to full width before
            // releasing chip select.
            TAIL: begin
               adc_sclk <= clk5M_in;
               if (!clk5M_in) begin
                  state <= DONE;
               end
            end

            DONE: begin
               adc_cs_n     <= 1'b1;
               adc_sclk     <= 1'b0;
               sample_data  <= shreg;
               sample_valid <= 1'b1;
               bit_cnt      <= '0;
               state        <= IDLE;
            end

            default: begin
               adc_cs_n <= 1'b1;
               adc_sclk <= 1'b0;
               bit_cnt  <= '0;
               state    <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_adc_serial_capture.sv
`timescale 1ns/1ps
module tb_adc_serial_capture;

   localparam int DB       = 10;
   localparam int FRAME    = 326;
   localparam int HALF_BIT = 15;
   localparam int BIT_P    = 2 * HALF_BIT;

   logic          clk150M_in = 1'b0;
   logic          rst_n;
   logic          enable;
   logic          clk470k_in;
   logic          clk5M_in;
   logic          adc_sdo;
   logic          adc_cs_n;
   logic          adc_sclk;
   logic [DB-1:0] sample_data;
   logic          sample_valid;
   logic          overrun;

   adc_serial_capture #(.DATA_BITS(DB)) dut (
      .clk150M_in   (clk150M_in),
      .rst_n        (rst_n),
      .enable       (enable),
      .clk470k_in   (clk470k_in),
      .clk5M_in     (clk5M_in),
      .adc_sdo      (adc_sdo),
      .adc_cs_n     (adc_cs_n),
      .adc_sclk     (adc_sclk),
      .sample_data  (sample_data),
      .sample_valid (sample_valid),
      .overrun      (overrun)
   );

   always #3.333 clk150M_in = ~clk150M_in;

   initial begin
      #1000000;
      $display("FAIL watchdog: time limit reached before the test finished");
      $fatal(1, "watchdog");
   end

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string name, input int got, input int exp);
      n_cmp++;
      if (got != exp) begin
         n_err++;
         $display("FAIL %s: got %0h, required %0h (t=%0t)", name, got, exp, $time);
      end
   endtask

   task automatic check_range(input string name, input int got, input int lo, input int hi);
      n_cmp++;
      if (got < lo || got > hi) begin
         n_err++;
         $display("FAIL %s: got %0d, required %0d..%0d (t=%0t)", name, got, lo, hi, $time);
      end
   endtask

   // Divider emulation, ADC model and protocol observer state
   int            fcnt = 0;
   int            bcnt = 0;
   bit            glitch_now = 1'b0;
   logic [DB-1:0] next_word = '0;

   logic          prev_cs = 1'b1;
   logic          prev_sclk = 1'b0;
   bit            in_win = 1'b0;
   bit            seen_rise = 1'b0;
   bit            have_gap = 1'b0;
   int            lead = 0;
   int            hi_len = 0;
   int            gap_len = 0;
   int            win_pulses = 0;
   int            valid_cnt = 0;
   int            ovr_cnt = 0;
   int            cs_fall_cnt = 0;
   logic          bitq[$];
   logic [DB-1:0] exp_q[$];

   // Observer + ADC: the ADC presents the MSB once cs_n falls and moves to the
   // next bit after every sclk falling edge. Each selected frame must come back
   // as exactly the word that was put on the wire.
   task automatic monitor_step();
      if (!rst_n) begin
         bitq.delete();
         exp_q.delete();
         in_win    = 1'b0;
         have_gap  = 1'b0;
         win_pulses = 0;
         prev_cs   = 1'b1;
         prev_sclk = 1'b0;
         adc_sdo   = 1'($urandom);
         return;
      end
      if (prev_cs && !adc_cs_n) begin
         cs_fall_cnt++;
         if (have_gap) check_range("cs_high_gap", gap_len, 9, 1 << 30);
         in_win     = 1'b1;
         seen_rise  = 1'b0;
         lead       = 0;
         win_pulses = 0;
         for (int i = DB - 1; i >= 0; i--) bitq.push_back(next_word[i]);
         exp_q.push_back(next_word);
      end else if (in_win && !adc_cs_n) begin
         lead++;
      end
      if (!prev_sclk && adc_sclk) begin
         check("sclk_rise_inside_cs_window", int'(adc_cs_n), 0);
         if (in_win && !seen_rise) begin
            seen_rise = 1'b1;
            check_range("cs_fall_to_first_sclk_rise", lead, 2, 31);
         end
         hi_len = 1;
      end else if (prev_sclk && adc_sclk) begin
         hi_len++;
      end
      if (prev_sclk && !adc_sclk) begin
         check("sclk_high_width", hi_len, HALF_BIT);
         win_pulses++;
         if (bitq.size() > 0) void'(bitq.pop_front());
      end
      if (!prev_cs && adc_cs_n) begin
         if (in_win) check("sclk_pulses_per_frame", win_pulses, DB);
         in_win   = 1'b0;
         have_gap = 1'b1;
         gap_len  = 1;
      end else if (adc_cs_n) begin
         gap_len++;
      end
      if (sample_valid) begin
         valid_cnt++;
         if (exp_q.size() == 0) check("valid_without_frame", int'(sample_valid), 0);
         else check("sample_data_on_valid", int'(sample_data), int'(exp_q.pop_front()));
      end
      if (overrun) ovr_cnt++;
      adc_sdo   = (bitq.size() > 0) ? bitq[0] : 1'($urandom);
      prev_cs   = adc_cs_n;
      prev_sclk = adc_sclk;
   endtask

   // One system clock: observe at the falling edge, then advance the divider
   // levels just after the rising edge.
   task automatic tick();
      @(negedge clk150M_in);
      monitor_step();
      @(posedge clk150M_in);
      #1;
      fcnt       = (fcnt + 1) % FRAME;
      bcnt       = (bcnt + 1) % BIT_P;
      clk470k_in = (fcnt < FRAME / 2) && !glitch_now;
      clk5M_in   = (bcnt < HALF_BIT);
   endtask

   task automatic wait_fcnt(input int k);
      int n;
      n = 0;
      do begin
         tick();
         n++;
      end while (fcnt != k && n < 2 * FRAME);
      if (fcnt != k) check("wait_frame_phase", fcnt, k);
   endtask

   typedef struct {
      logic [DB-1:0] word;
      bit            en;
      bit            glitch;
      int            bph;
      int            exp_cs;
      int            exp_valid;
      int            exp_ovr;
      logic [DB-1:0] exp_data;
   } row_t;

   // One frame period: set up just before the strobe, optionally inject an
   // extra strobe edge 100 cycles in, then tally what the frame produced.
   task automatic run_frame(input row_t r);
      int v0, o0, c0;
      wait_fcnt(FRAME - 4);
      next_word = r.word;
      enable    = r.en;
      if (r.bph >= 0) bcnt = r.bph;
      v0 = valid_cnt;
      o0 = ovr_cnt;
      c0 = cs_fall_cnt;
      if (r.glitch) begin
         wait_fcnt(100);
         glitch_now = 1'b1;
         tick();
         glitch_now = 1'b0;
      end
      wait_fcnt(FRAME - 5);
      check("frame_cs_windows", cs_fall_cnt - c0, r.exp_cs);
      check("frame_valid_pulses", valid_cnt - v0, r.exp_valid);
      check("frame_overrun_pulses", ovr_cnt - o0, r.exp_ovr);
      check("frame_sample_data", int'(sample_data), int'(r.exp_data));
   endtask

   row_t tbl[16];
   row_t rr;

   initial begin
      int n, v0;
      rst_n      = 1'b0;
      enable     = 1'b0;
      clk470k_in = 1'b0;
      clk5M_in   = 1'b0;
      adc_sdo    = 1'b0;

      //            word     en    glt   bph  cs val ovr data
      tbl[0]  = '{10'h2A5, 1'b1, 1'b0, -1, 1, 1, 0, 10'h2A5};
      tbl[1]  = '{10'h000, 1'b1, 1'b0, -1, 1, 1, 0, 10'h000};
      tbl[2]  = '{10'h3FF, 1'b1, 1'b0, -1, 1, 1, 0, 10'h3FF};
      tbl[3]  = '{10'h155, 1'b1, 1'b0, -1, 1, 1, 0, 10'h155};
      tbl[4]  = '{10'h2AA, 1'b1, 1'b0, -1, 1, 1, 0, 10'h2AA};
      tbl[5]  = '{10'h0F0, 1'b1, 1'b0, -1, 1, 1, 0, 10'h0F0};
      tbl[6]  = '{10'h30C, 1'b1, 1'b0, -1, 1, 1, 0, 10'h30C};
      tbl[7]  = '{10'h001, 1'b1, 1'b0, -1, 1, 1, 0, 10'h001};
      tbl[8]  = '{10'h200, 1'b1, 1'b0, -1, 1, 1, 0, 10'h200};
      tbl[9]  = '{10'h1E7, 1'b1, 1'b1, -1, 1, 1, 1, 10'h1E7};
      tbl[10] = '{10'h0AB, 1'b0, 1'b0, -1, 0, 0, 0, 10'h1E7};
      tbl[11] = '{10'h3C5, 1'b0, 1'b0, -1, 0, 0, 0, 10'h1E7};
      tbl[12] = '{10'h111, 1'b0, 1'b0, -1, 0, 0, 0, 10'h1E7};
      tbl[13] = '{10'h2D2, 1'b1, 1'b0, -1, 1, 1, 0, 10'h2D2};
      tbl[14] = '{10'h2A5, 1'b1, 1'b0,  1, 1, 1, 0, 10'h2A5};
      tbl[15] = '{10'h2A5, 1'b1, 1'b0, 16, 1, 1, 0, 10'h2A5};

      repeat (3) tick();
      check("reset_cs_n", int'(adc_cs_n), 1);
      check("reset_sclk", int'(adc_sclk), 0);
      check("reset_sample_data", int'(sample_data), 0);
      check("reset_sample_valid", int'(sample_valid), 0);
      check("reset_overrun", int'(overrun), 0);

      wait_fcnt(200);
      rst_n  = 1'b1;
      enable = 1'b1;

      for (int i = 0; i < 16; i++) run_frame(tbl[i]);

      // Reset in the middle of the shift phase, after five bits.
      wait_fcnt(FRAME - 4);
      next_word = 10'h1C3;
      enable    = 1'b1;
      v0        = valid_cnt;
      wait_fcnt(20);
      n = 0;
      while (win_pulses < 5 && n < FRAME) begin
         tick();
         n++;
      end
      check("pre_reset_five_bits", win_pulses, 5);
      check("pre_reset_cs_low", int'(adc_cs_n), 0);
      rst_n = 1'b0;
      #1;
      check("mid_reset_cs_n", int'(adc_cs_n), 1);
      check("mid_reset_sclk", int'(adc_sclk), 0);
      check("mid_reset_sample_valid", int'(sample_valid), 0);
      check("mid_reset_sample_data", int'(sample_data), 0);
      wait_fcnt(200);
      rst_n = 1'b1;
      wait_fcnt(FRAME - 5);
      check("reset_frame_no_valid", valid_cnt - v0, 0);
      run_frame('{10'h19B, 1'b1, 1'b0, -1, 1, 1, 0, 10'h19B});

      for (int i = 0; i < 12; i++) begin
         rr.word      = DB'($urandom_range(0, (1 << DB) - 1));
         rr.en        = 1'b1;
         rr.glitch    = 1'b0;
         rr.bph       = int'($urandom_range(0, BIT_P)) - 1;
         rr.exp_cs    = 1;
         rr.exp_valid = 1;
         rr.exp_ovr   = 0;
         rr.exp_data  = rr.word;
         run_frame(rr);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
